pcm_serial_rx: RTL

Serial PCM receiver sitting directly upstream of the expander in the encoder path. It deserializes 8-bit A-law/u-law code words from a frame-synchronized serial line, tags each with the companding law in force when its MSB arrived, and buffers them in a small FIFO. The FIFO presents code word and law to the expander through a valid/ready handshake. It also reports framing errors and overruns.

---
 rtl/mcac_pkg.sv | 6 +
 rtl/pcm_fifo.sv | 53 +++++
 rtl/pcm_serial_rx.sv | 64 ++++++
 3 files changed

// File: rtl/mcac_pkg.sv
// mcac_pkg: shared PCM word width, FIFO entry width and receive state type
package mcac_pkg;
    localparam int PCM_W = 8;
    localparam int ENTRY_W = PCM_W + 1;
    typedef enum logic {HUNT, SHIFT} rx_state_e;
endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: show-ahead FIFO; head, valid and level are all registers
module pcm_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       rd,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic                       full,
    output logic                       ovf,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rnext;
    logic [AW:0] cnt_n;
    logic [W-1:0] head_n;
    logic pop, wr;
    always_comb begin
        pop = valid && rd;
        full = level == (AW+1)'(DEPTH);
        wr = push && (!full || pop);
        ovf = push && full && !pop;
        cnt_n = level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
        rnext = rptr + AW'(1);
        // the incoming word becomes head when the queue was empty or is being emptied
        head_n = cnt_n == '0 ? '0
               : (level == '0 || (pop && level == (AW+1)'(1))) ? din
               : pop ? mem[rnext] : dout;
    end
    always_ff @(posedge clk)
        if (wr)
            mem[wptr] <= din;
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            dout <= '0;
            valid <= 1'b0;
        end else begin
            wptr <= wr ? wptr + AW'(1) : wptr;
            rptr <= pop ? rnext : rptr;
            level <= cnt_n;
            dout <= head_n;
            valid <= cnt_n != '0;
        end
    end
endmodule

// File: rtl/pcm_serial_rx.sv
// pcm_serial_rx: frame-synced serial PCM deserializer with law tagging and output FIFO
module pcm_serial_rx
    import mcac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_en,
    input  logic                   sdi,
    input  logic                   fs,
    input  logic                   law_cfg,
    output logic [PCM_W-1:0]       sin,
    output logic                   law,
    output logic                   s_valid,
    input  logic                   s_ready,
    output logic                   ferr,
    output logic                   ovr,
    output logic [$clog2(DEPTH):0] level
);
    rx_state_e state, state_n;
    logic [2:0] bcnt;
    logic [PCM_W-1:0] sr;
    logic lawq, msb, shift_bit, push, ferr_n, ovf, full;
    always_ff @(posedge clk)
        state <= reset ? HUNT : state_n;
    always_comb
        state_n = (bit_en && fs) ? SHIFT
                : (bit_en && state == SHIFT && bcnt == 3'd7) ? HUNT : state;
    // FS always restarts a word; in SHIFT it also flags the abandoned partial word
    always_comb begin
        msb = bit_en && fs;
        shift_bit = bit_en && !fs && state == SHIFT;
        push = shift_bit && bcnt == 3'd7;
        ferr_n = msb && state == SHIFT;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt <= '0;
            sr <= '0;
            lawq <= 1'b0;
            ferr <= 1'b0;
            ovr <= 1'b0;
        end else begin
            sr <= (msb || shift_bit) ? {sr[PCM_W-2:0], sdi} : sr;
            bcnt <= msb ? 3'd1 : shift_bit ? bcnt + 3'd1 : bcnt;
            lawq <= msb ? law_cfg : lawq;
            ferr <= ferr_n;
            ovr <= ovf;
        end
    end
    pcm_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({lawq, sr[PCM_W-2:0], sdi}),
        .rd    (s_ready),
        .dout  ({law, sin}),
        .valid (s_valid),
        .full  (full),
        .ovf   (ovf),
        .level (level)
    );
endmodule
